// File: rtl/memory_bus_responder_pkg.sv
// Shared types and constants for the memory bus responder: FSM states,
// decoded regions, the I/O page bounds and the wait-counter width.
package memory_bus_responder_pkg;

  localparam int WAIT_W = 3;

  localparam logic [15:0] IO_PAGE_LO = 16'h7F00;
  localparam logic [15:0] IO_PAGE_HI = 16'h7FFF;

  typedef enum logic [2:0] {IDLE, SETUP, WAIT, DONE, RELEASE} state_t;

  typedef enum logic [1:0] {ROM, RAM, IO} region_t;

endpackage

// File: rtl/memory_bus_responder_if.sv
// Request side and external-memory side of the responder as one bundle.
// The io_cs_n chip select exists only when MEMORY_BUS_RESPONDER_IO_EN is defined.
interface memory_bus_responder_if;

  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  rdata;
  logic        rdata_oe_n;
  logic        ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        rom_cs_n;
  logic        ram_cs_n;
  logic        mem_oe_n;
  logic        mem_we_n;
`ifdef MEMORY_BUS_RESPONDER_IO_EN
  logic        io_cs_n;
`endif

  modport slave (
`ifdef MEMORY_BUS_RESPONDER_IO_EN
    output io_cs_n,
`endif
    input  addr, wdata, rd_n, wr_n, mem_din,
    output rdata, rdata_oe_n, ready, mem_addr, mem_dout,
    output rom_cs_n, ram_cs_n, mem_oe_n, mem_we_n
  );

  modport master (
`ifdef MEMORY_BUS_RESPONDER_IO_EN
    input  io_cs_n,
`endif
    output addr, wdata, rd_n, wr_n, mem_din,
    input  rdata, rdata_oe_n, ready, mem_addr, mem_dout,
    input  rom_cs_n, ram_cs_n, mem_oe_n, mem_we_n
  );

endinterface

// File: rtl/memory_bus_responder_wait_state_counter.sv
// Wait-state down-counter driven by the responder FSM: load, decrement
// (saturating at zero) and a zero flag.
module wait_state_counter
  import memory_bus_responder_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic              load,
  input  logic              dec,
  input  logic [WAIT_W-1:0] load_val,
  output logic [WAIT_W-1:0] count,
  output logic              zero
);

  always_ff @(posedge clock) begin
    if (clear)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/memory_bus_responder.sv
// Memory bus responder: decodes a captured request into ROM/RAM(/I/O),
// sequences chip select, OE and WE with per-region wait states and returns read
// data. Optional I/O page enabled by MEMORY_BUS_RESPONDER_IO_EN.
module memory_bus_responder
  import memory_bus_responder_pkg::*;
#(
  parameter logic [15:0] RAM_BASE = 16'h8000,
  parameter int          ROM_WAIT = 2,
  parameter int          RAM_WAIT = 1
)(
  input  logic                   clock,
  input  logic                   clear,
  memory_bus_responder_if.slave  bus
);

  localparam logic [WAIT_W-1:0] ROM_W = WAIT_W'(ROM_WAIT);
  localparam logic [WAIT_W-1:0] RAM_W = WAIT_W'(RAM_WAIT);

  state_t            state, next_state;
  region_t           region, addr_region;
  logic              is_read;
  logic              capture;
  logic [15:0]       addr_q;
  logic [7:0]        wdata_q;
  logic [7:0]        rdata_q;
  logic              load, dec, zero;
  logic [WAIT_W-1:0] count, load_val;
  logic              cs_on, oe_on, we_on, ready_on, write_ok;

  always_comb begin
    addr_region = ROM;
    if (bus.addr >= RAM_BASE)
      addr_region = RAM;
`ifdef MEMORY_BUS_RESPONDER_IO_EN
    else if (bus.addr >= IO_PAGE_LO && bus.addr <= IO_PAGE_HI)
      addr_region = IO;
`endif
  end

  assign capture  = (state == IDLE) && (!bus.rd_n || !bus.wr_n);
  assign load_val = (region == RAM) ? RAM_W : ROM_W;
  assign write_ok = !is_read && (region != ROM);

  wait_state_counter u_wait (
    .clock    (clock),
    .clear    (clear),
    .load     (load),
    .dec      (dec),
    .load_val (load_val),
    .count    (count),
    .zero     (zero)
  );

  // WE is pulsed only in the cycle that hands over to DONE.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    dec        = 1'b0;
    cs_on      = 1'b0;
    oe_on      = 1'b0;
    we_on      = 1'b0;
    ready_on   = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.rd_n || !bus.wr_n)
          next_state = SETUP;
      end
      SETUP: begin
        cs_on = 1'b1;
        oe_on = is_read;
        load  = 1'b1;
        if (load_val == '0) begin
          next_state = DONE;
          we_on      = write_ok;
        end else begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        cs_on = 1'b1;
        oe_on = is_read;
        dec   = 1'b1;
        if (zero || count == WAIT_W'(1)) begin
          next_state = DONE;
          we_on      = write_ok;
        end
      end
      DONE: begin
        cs_on      = 1'b1;
        oe_on      = is_read;
        ready_on   = 1'b1;
        next_state = RELEASE;
      end
      RELEASE: begin
        if (bus.rd_n && bus.wr_n)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= IDLE;
      region  <= ROM;
      is_read <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= next_state;
      if (capture) begin
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        is_read <= !bus.rd_n;
        region  <= addr_region;
      end
      if (is_read && (state == SETUP || state == WAIT) && next_state == DONE)
        rdata_q <= bus.mem_din;
    end
  end

  assign bus.mem_addr   = addr_q;
  assign bus.mem_dout   = wdata_q;
  assign bus.rdata      = rdata_q;
  assign bus.ready      = ready_on;
  assign bus.mem_oe_n   = !oe_on;
  assign bus.mem_we_n   = !we_on;
  assign bus.rom_cs_n   = !(cs_on && region == ROM);
  assign bus.ram_cs_n   = !(cs_on && region == RAM);
`ifdef MEMORY_BUS_RESPONDER_IO_EN
  assign bus.io_cs_n    = !(cs_on && region == IO);
`endif
  assign bus.rdata_oe_n = !((state == DONE || state == RELEASE) && is_read && !bus.rd_n);

endmodule
